// File: rtl/fft_peak_detect.sv
// -----------------------------------------------------------------------------
// fft_peak_detect
//
// Streaming spectral peak detector for the output of fft_1024_s. Each input
// beat carries one FFT bin; the block squares and sums its components to get
// the bin power, tracks the strongest eligible bin of the frame and reports it
// with a one-cycle strobe when the frame closes. Frames whose length is not
// exactly N bins are reported with an error strobe and their result is dropped.
//
// Ports:
//   clk      in   1        sole clock, rising edge
//   rst      in   1        asynchronous active-high reset
//   di_en    in   1        input beat valid (FFT do_en)
//   di_last  in   1        final beat of a frame, qualified by di_en
//   din      in   2*DW     {imag, real}, two's complement
//   pk_en    out  1        strobe: new result on pk_bin / pk_pow
//   pk_bin   out  N_LOG2   bin index of the frame maximum
//   pk_pow   out  2*DW     unsigned peak power re^2 + im^2
//   frm_err  out  1        strobe: malformed frame, result discarded
//
// Pipeline (edge T samples the input beat):
//   T   : input registers (data + tags)
//   T+1 : squares
//   T+2 : sum
//   T+3 : running maximum update
//   T+4 : output registers / strobes
// -----------------------------------------------------------------------------
module fft_peak_detect #(
    parameter int N_LOG2  = 10,
    parameter int DW      = 16,
    parameter int SKIP_DC = 1,
    parameter int HALF    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              di_en,
    input  logic              di_last,
    input  logic [2*DW-1:0]   din,
    output logic              pk_en,
    output logic [N_LOG2-1:0] pk_bin,
    output logic [2*DW-1:0]   pk_pow,
    output logic              frm_err
);

    localparam logic [N_LOG2-1:0] LAST_BIN = {N_LOG2{1'b1}};
    localparam logic [N_LOG2-1:0] ZERO_BIN = {N_LOG2{1'b0}};
    localparam logic [N_LOG2-1:0] ONE_BIN  = {{(N_LOG2-1){1'b0}}, 1'b1};

    // Square of a signed component; the result is never negative and at most
    // 2^(2DW-2), so it is returned as an unsigned 2*DW value.
    function automatic logic [2*DW-1:0] square(input logic signed [DW-1:0] x);
        logic signed [2*DW-1:0] xe;
        xe = {{DW{x[DW-1]}}, x};
        return xe * xe;
    endfunction

    // ---------------------------------------------------------------- input
    logic [N_LOG2-1:0] bcnt_r;
    logic [N_LOG2-1:0] bcnt_nxt_s;
    logic              at_last_s;
    logic              elig_s;
    logic              end_ok_s;
    logic              end_err_s;

    // Bin counter advance, eligibility and frame-boundary classification.
    always_comb begin
        bcnt_nxt_s = bcnt_r;
        at_last_s  = (bcnt_r == LAST_BIN);
        elig_s     = 1'b1;
        end_ok_s   = 1'b0;
        end_err_s  = 1'b0;
        if ((SKIP_DC != 0) && (bcnt_r == ZERO_BIN)) begin
            elig_s = 1'b0;
        end else if ((HALF != 0) && bcnt_r[N_LOG2-1]) begin
            elig_s = 1'b0;
        end else begin
            elig_s = 1'b1;
        end
        if (di_en) begin
            if (di_last || at_last_s) begin
                bcnt_nxt_s = ZERO_BIN;
            end else begin
                bcnt_nxt_s = bcnt_r + ONE_BIN;
            end
            // Good frame: last marker exactly on bin N-1. Short frame: marker
            // early. Long frame: bin N-1 passes without a marker.
            end_ok_s  = di_last & at_last_s;
            end_err_s = di_last ^ at_last_s;
        end else begin
            bcnt_nxt_s = bcnt_r;
        end
    end

    // Bin counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_r <= ZERO_BIN;
        end else begin
            bcnt_r <= bcnt_nxt_s;
        end
    end

    // ---------------------------------------------------------------- S1
    logic                    s1_v_r;
    logic                    s1_elig_r;
    logic                    s1_ok_r;
    logic                    s1_err_r;
    logic [N_LOG2-1:0]       s1_bin_r;
    logic signed [DW-1:0]    s1_re_r;
    logic signed [DW-1:0]    s1_im_r;

    // S1: capture the beat and its tags; idle cycles carry all-zero tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_r    <= 1'b0;
            s1_elig_r <= 1'b0;
            s1_ok_r   <= 1'b0;
            s1_err_r  <= 1'b0;
            s1_bin_r  <= ZERO_BIN;
            s1_re_r   <= {DW{1'b0}};
            s1_im_r   <= {DW{1'b0}};
        end else begin
            s1_v_r    <= di_en;
            s1_elig_r <= di_en & elig_s;
            s1_ok_r   <= end_ok_s;
            s1_err_r  <= end_err_s;
            if (di_en) begin
                s1_bin_r <= bcnt_r;
                s1_re_r  <= din[DW-1:0];
                s1_im_r  <= din[2*DW-1:DW];
            end else begin
                s1_bin_r <= s1_bin_r;
                s1_re_r  <= s1_re_r;
                s1_im_r  <= s1_im_r;
            end
        end
    end

    // ---------------------------------------------------------------- S2
    logic                    s2_v_r;
    logic                    s2_elig_r;
    logic                    s2_ok_r;
    logic                    s2_err_r;
    logic [N_LOG2-1:0]       s2_bin_r;
    logic [2*DW-1:0]         s2_re2_r;
    logic [2*DW-1:0]         s2_im2_r;

    // S2: square both components.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_r    <= 1'b0;
            s2_elig_r <= 1'b0;
            s2_ok_r   <= 1'b0;
            s2_err_r  <= 1'b0;
            s2_bin_r  <= ZERO_BIN;
            s2_re2_r  <= {(2*DW){1'b0}};
            s2_im2_r  <= {(2*DW){1'b0}};
        end else begin
            s2_v_r    <= s1_v_r;
            s2_elig_r <= s1_elig_r;
            s2_ok_r   <= s1_ok_r;
            s2_err_r  <= s1_err_r;
            if (s1_v_r) begin
                s2_bin_r <= s1_bin_r;
                s2_re2_r <= square(s1_re_r);
                s2_im2_r <= square(s1_im_r);
            end else begin
                s2_bin_r <= s2_bin_r;
                s2_re2_r <= s2_re2_r;
                s2_im2_r <= s2_im2_r;
            end
        end
    end

    // ---------------------------------------------------------------- S3
    logic                    s3_elig_r;
    logic                    s3_ok_r;
    logic                    s3_err_r;
    logic [N_LOG2-1:0]       s3_bin_r;
    logic [2*DW-1:0]         s3_pow_r;

    // S3: power sum. Each square is <= 2^(2DW-2), so the sum fits in 2*DW bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_elig_r <= 1'b0;
            s3_ok_r   <= 1'b0;
            s3_err_r  <= 1'b0;
            s3_bin_r  <= ZERO_BIN;
            s3_pow_r  <= {(2*DW){1'b0}};
        end else begin
            s3_elig_r <= s2_elig_r;
            s3_ok_r   <= s2_ok_r;
            s3_err_r  <= s2_err_r;
            if (s2_v_r) begin
                s3_bin_r <= s2_bin_r;
                s3_pow_r <= s2_re2_r + s2_im2_r;
            end else begin
                s3_bin_r <= s3_bin_r;
                s3_pow_r <= s3_pow_r;
            end
        end
    end

    // ---------------------------------------------------------------- S4
    logic                    seen_r;
    logic                    s4_ok_r;
    logic                    s4_err_r;
    logic [N_LOG2-1:0]       max_bin_r;
    logic [2*DW-1:0]         max_pow_r;
    logic                    take_s;

    // Load on the first eligible bin of a frame, then only on a strictly
    // larger power so that ties keep the lowest bin.
    always_comb begin
        take_s = 1'b0;
        if (s3_elig_r && (!seen_r || (s3_pow_r > max_pow_r))) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // S4: running maximum. A frame boundary clears seen_r so the next frame
    // reloads from scratch while max_*_r still hold this frame's winner for
    // the output stage one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_r    <= 1'b0;
            s4_ok_r   <= 1'b0;
            s4_err_r  <= 1'b0;
            max_bin_r <= ZERO_BIN;
            max_pow_r <= {(2*DW){1'b0}};
        end else begin
            s4_ok_r  <= s3_ok_r;
            s4_err_r <= s3_err_r;
            if (s3_ok_r || s3_err_r) begin
                seen_r <= 1'b0;
            end else if (s3_elig_r) begin
                seen_r <= 1'b1;
            end else begin
                seen_r <= seen_r;
            end
            if (take_s) begin
                max_bin_r <= s3_bin_r;
                max_pow_r <= s3_pow_r;
            end else begin
                max_bin_r <= max_bin_r;
                max_pow_r <= max_pow_r;
            end
        end
    end

    // Output registers: commit on a good frame, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pk_en   <= 1'b0;
            frm_err <= 1'b0;
            pk_bin  <= ZERO_BIN;
            pk_pow  <= {(2*DW){1'b0}};
        end else begin
            pk_en   <= s4_ok_r;
            frm_err <= s4_err_r;
            if (s4_ok_r) begin
                pk_bin <= max_bin_r;
                pk_pow <= max_pow_r;
            end else begin
                pk_bin <= pk_bin;
                pk_pow <= pk_pow;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// -----------------------------------------------------------------------------
// tb_fft_peak_detect
//
// Directed bench for fft_peak_detect with default parameters (N=1024, DW=16,
// SKIP_DC=1, HALF=1). Each frame's expected strobe (kind, bin, power and the
// exact cycle it must appear) is pushed into a scoreboard queue when the
// closing beat is driven; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_fft_peak_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        di_en;
    logic        di_last;
    logic [31:0] din;
    logic        pk_en;
    logic [9:0]  pk_bin;
    logic [31:0] pk_pow;
    logic        frm_err;

    fft_peak_detect dut (
        .clk     (clk),
        .rst     (rst),
        .di_en   (di_en),
        .di_last (di_last),
        .din     (din),
        .pk_en   (pk_en),
        .pk_bin  (pk_bin),
        .pk_pow  (pk_pow),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [9:0]  bin;
        logic [31:0] pow;
        int          at;
    } exp_t;

    exp_t sb[$];

    logic signed [15:0] re_a [1024];
    logic signed [15:0] im_a [1024];
    logic [9:0]  last_bin = 10'd0;
    logic [31:0] last_pow = 32'd0;

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        ntot++;
        assert (obs === req) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    endtask

    function automatic logic [31:0] power(input logic signed [15:0] r, input logic signed [15:0] i);
        logic signed [31:0] a;
        logic signed [31:0] b;
        a = r * r;
        b = i * i;
        return $unsigned(a) + $unsigned(b);
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < 1024; i++) begin
            re_a[i] = 16'sd0;
            im_a[i] = 16'sd0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            di_en   = 1'b0;
            di_last = 1'b0;
        end
    endtask

    // Drive nbeats bins starting at bin 0. The task leaves di_en high after
    // the last beat so consecutive calls are back-to-back.
    task automatic send_frame(input int nbeats, input bit with_last, input bit gaps);
        int          lim;
        logic [31:0] mp;
        logic [9:0]  mb;
        logic [31:0] p;
        bit          seen;
        lim  = (nbeats < 512) ? nbeats : 512;
        mp   = 32'd0;
        mb   = 10'd0;
        seen = 1'b0;
        for (int b = 1; b < lim; b++) begin
            p = power(re_a[b], im_a[b]);
            if (!seen || (p > mp)) begin
                mp   = p;
                mb   = 10'(b);
                seen = 1'b1;
            end
        end
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
            @(negedge clk);
            di_en   = 1'b1;
            din     = {im_a[b], re_a[b]};
            di_last = with_last && (b == nbeats - 1);
            if (di_last) begin
                if (nbeats == 1024) begin
                    sb.push_back('{1'b0, mb, mp, cyc + 5});
                    last_bin = mb;
                    last_pow = mp;
                end else begin
                    sb.push_back('{1'b1, last_bin, last_pow, cyc + 5});
                end
            end else if (b == 1023) begin
                sb.push_back('{1'b1, last_bin, last_pow, cyc + 5});
            end
        end
    endtask

    // Scoreboard monitor: compare each strobe and flag any that is overdue.
    always @(negedge clk) begin
        if (!rst) begin
            if (pk_en || frm_err) begin
                exp_t e;
                chk("exclusive", {63'd0, pk_en & frm_err}, 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("kind_err", {63'd0, frm_err}, {63'd0, e.is_err});
                    chk("kind_pk", {63'd0, pk_en}, {63'd0, !e.is_err});
                    chk("pk_bin", {54'd0, pk_bin}, {54'd0, e.bin});
                    chk("pk_pow", {32'd0, pk_pow}, {32'd0, e.pow});
                    chk("latency", 64'(cyc), 64'(e.at));
                end
            end
            if ((sb.size() > 0) && (sb[0].at < cyc)) begin
                chk("missing_strobe", 64'(cyc), 64'(sb[0].at));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int t;
        rst     = 1'b1;
        di_en   = 1'b0;
        di_last = 1'b0;
        din     = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_pk_en", {63'd0, pk_en}, 64'd0);
        chk("rst_frm_err", {63'd0, frm_err}, 64'd0);
        chk("rst_pk_bin", {54'd0, pk_bin}, 64'd0);
        chk("rst_pk_pow", {32'd0, pk_pow}, 64'd0);
        rst = 1'b0;
        idle(2);

        // 1: clean tone at bin 37
        clear_frame();
        re_a[37] = 16'sd1000;
        send_frame(1024, 1'b1, 1'b0);
        idle(10);
        chk("t1_bin", {54'd0, pk_bin}, 64'd37);
        chk("t1_pow", {32'd0, pk_pow}, 64'd1000000);

        // 2: extremes, excluded DC and upper half, tie between 10 and 20
        clear_frame();
        re_a[0]   = 16'sd30000;
        re_a[5]   = -16'sd32768;
        im_a[5]   = -16'sd32768;
        re_a[600] = 16'sd32767;
        im_a[600] = 16'sd32767;
        re_a[10]  = 16'sd100;
        re_a[20]  = 16'sd100;
        send_frame(1024, 1'b1, 1'b0);
        idle(10);
        chk("t2_bin", {54'd0, pk_bin}, 64'd5);
        chk("t2_pow", {32'd0, pk_pow}, 64'h8000_0000);
        re_a[5] = 16'sd0;
        im_a[5] = 16'sd0;
        send_frame(1024, 1'b1, 1'b0);
        idle(10);
        chk("t2b_bin", {54'd0, pk_bin}, 64'd10);
        chk("t2b_pow", {32'd0, pk_pow}, 64'd10000);

        // 3: short frame (last on beat 500), then a good frame
        clear_frame();
        re_a[100] = 16'sd500;
        send_frame(501, 1'b1, 1'b0);
        idle(10);
        chk("t3_hold_bin", {54'd0, pk_bin}, 64'd10);
        chk("t3_hold_pow", {32'd0, pk_pow}, 64'd10000);
        clear_frame();
        re_a[300] = -16'sd2000;
        im_a[300] = 16'sd7;
        send_frame(1024, 1'b1, 1'b0);
        idle(10);

        // 4: long frame followed directly by a good frame
        clear_frame();
        re_a[400] = 16'sd3000;
        send_frame(1024, 1'b0, 1'b0);
        clear_frame();
        re_a[250] = 16'sd1234;
        im_a[250] = -16'sd99;
        send_frame(1024, 1'b1, 1'b0);
        idle(10);

        // 5: back-to-back frames, peaks at 1, 511, 200; then with gaps
        for (int g = 0; g < 2; g++) begin
            clear_frame();
            re_a[1] = 16'sd50;
            send_frame(1024, 1'b1, g[0]);
            clear_frame();
            im_a[511] = -16'sd60;
            re_a[512] = 16'sd30000;
            send_frame(1024, 1'b1, g[0]);
            clear_frame();
            re_a[200] = 16'sd70;
            im_a[200] = 16'sd70;
            send_frame(1024, 1'b1, g[0]);
            idle(10);
        end
        chk("t5_bin", {54'd0, pk_bin}, 64'd200);

        // 6: reset in the middle of a frame, then a frame peaking at bin 3
        clear_frame();
        re_a[50] = 16'sd9999;
        send_frame(700, 1'b0, 1'b0);
        @(negedge clk);
        rst   = 1'b1;
        di_en = 1'b0;
        #1;
        chk("t6_rst_bin", {54'd0, pk_bin}, 64'd0);
        chk("t6_rst_pow", {32'd0, pk_pow}, 64'd0);
        chk("t6_rst_en", {63'd0, pk_en | frm_err}, 64'd0);
        repeat (2) @(negedge clk);
        last_bin = 10'd0;
        last_pow = 32'd0;
        rst      = 1'b0;
        clear_frame();
        re_a[3] = 16'sd77;
        send_frame(1024, 1'b1, 1'b0);
        idle(10);
        chk("t6_bin", {54'd0, pk_bin}, 64'd3);
        chk("t6_pow", {32'd0, pk_pow}, 64'd5929);

        t = 0;
        while ((sb.size() > 0) && (t < 50)) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
